// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table: 2-bit counter
// encodings and the table control states.
package bht_pkg;

    localparam logic [1:0] STRONGLY_NOT_TAKEN = 2'b00;
    localparam logic [1:0] WEAKLY_NOT_TAKEN   = 2'b01;
    localparam logic [1:0] WEAKLY_TAKEN       = 2'b10;
    localparam logic [1:0] STRONGLY_TAKEN     = 2'b11;

    localparam logic [1:0] RESET_COUNTER = WEAKLY_TAKEN;

    typedef enum logic {
        INIT,
        RUN
    } bht_state_t;

endpackage

// File: rtl/counter_2bit_next.sv
// Next-state and prediction of one 2-bit saturating counter.
import bht_pkg::*;

module counter_2bit_next (
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next,
    output logic       predict
);

    always_comb begin
        next = state;
        if (taken) begin
            if (state != STRONGLY_TAKEN)
                next = state + 2'd1;
        end else begin
            if (state != STRONGLY_NOT_TAKEN)
                next = state - 2'd1;
        end
        predict = next[1];
    end

endmodule

// File: rtl/branch_history_table.sv
// Pattern history table of 2-bit counters, swept to weakly-taken after reset.
// Define BHT_GSHARE_EN to XOR a global history register into the lookup index.
import bht_pkg::*;

module branch_history_table #(
    parameter int INDEX_BITS = 6,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  lookupValid,
    input  logic [PC_WIDTH-1:0]   lookupPC,
    output logic                  predValid,
    output logic                  predTaken,
    output logic [INDEX_BITS-1:0] predIndex,
    input  logic                  updateValid,
    input  logic [INDEX_BITS-1:0] updateIndex,
    input  logic                  updateTaken
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_ENTRY = {INDEX_BITS{1'b1}};
    localparam logic [INDEX_BITS-1:0] ONE = 1;

    logic [1:0]            counters [ENTRIES];
    bht_state_t            state;
    logic [INDEX_BITS-1:0] initCount;
    logic [INDEX_BITS-1:0] pcIndex;
    logic [INDEX_BITS-1:0] lookupIndex;
    logic [1:0]            updNext;
    logic                  updPred;
    logic                  lookupPred;
    logic                  unused_pc_bits;

    assign pcIndex = lookupPC[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{lookupPC[PC_WIDTH-1:INDEX_BITS+2], lookupPC[1:0]};

`ifdef BHT_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ghr <= '0;
        else if (state == RUN && updateValid)
            ghr <= {ghr[INDEX_BITS-2:0], updateTaken};
    end

    assign lookupIndex = pcIndex ^ ghr;
`else
    assign lookupIndex = pcIndex;
`endif

    counter_2bit_next u_next (
        .state   (counters[updateIndex]),
        .taken   (updateTaken),
        .next    (updNext),
        .predict (updPred)
    );

    // Same-entry update this cycle: the prediction sees the trained counter.
    assign lookupPred = (updateValid && updateIndex == lookupIndex)
                      ? updPred : counters[lookupIndex][1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            initCount <= '0;
            ready     <= 1'b0;
            predValid <= 1'b0;
            predTaken <= 1'b0;
            predIndex <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    predValid <= 1'b0;
                    initCount <= initCount + ONE;
                    if (initCount == LAST_ENTRY) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    predValid <= lookupValid;
                    if (lookupValid) begin
                        predTaken <= lookupPred;
                        predIndex <= lookupIndex;
                    end
                end
            endcase
        end
    end

    // Storage has no reset; INIT gives every entry a defined value.
    always_ff @(posedge clk) begin
        if (state == INIT)
            counters[initCount] <= RESET_COUNTER;
        else if (updateValid)
            counters[updateIndex] <= updNext;
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Scoreboard bench for branch_history_table: randomized and directed
// lookups/updates checked against a plain array model of the counters.
module tb_branch_history_table;

    localparam int IB = 6;
    localparam int PW = 32;
    localparam int N  = 64;
`ifdef BHT_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ready;
    logic          lookupValid = 1'b0;
    logic [PW-1:0] lookupPC = '0;
    logic          predValid;
    logic          predTaken;
    logic [IB-1:0] predIndex;
    logic          updateValid = 1'b0;
    logic [IB-1:0] updateIndex = '0;
    logic          updateTaken = 1'b0;

    branch_history_table #(.INDEX_BITS(IB), .PC_WIDTH(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .lookupValid (lookupValid),
        .lookupPC    (lookupPC),
        .predValid   (predValid),
        .predTaken   (predTaken),
        .predIndex   (predIndex),
        .updateValid (updateValid),
        .updateIndex (updateIndex),
        .updateTaken (updateTaken)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int taken;
    } sb_t;

    sb_t sbq[$];
    sb_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  model[N];
    int  ghr = 0;
    int  last_t = 0;
    int  last_i = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pidx(input logic [31:0] pc);
        return int'(pc / 4) % N;
    endfunction

    function automatic int dx(input int x);
        return GSHARE ? -1 : x;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (predValid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pred: predValid=1 with no lookup outstanding");
                end else begin
                    mon_e = sbq.pop_front();
                    chk("pred_index", int'(predIndex), mon_e.idx);
                    chk("pred_taken", int'(predTaken), mon_e.taken);
                end
                last_t = int'(predTaken);
                last_i = int'(predIndex);
            end else begin
                chk("hold_taken", int'(predTaken), last_t);
                chk("hold_index", int'(predIndex), last_i);
            end
        end
    end

    task automatic step(input bit lv, input logic [31:0] pc, input bit uv,
                        input int ui, input bit ut,
                        input int et = -1, input int ei = -1);
        int  idx;
        sb_t e;
        @(posedge clk);
        #1;
        lookupValid = lv;
        lookupPC    = pc;
        updateValid = uv;
        updateIndex = ui[IB-1:0];
        updateTaken = ut;
        idx = GSHARE ? (pidx(pc) ^ ghr) : pidx(pc);
        if (uv) begin
            if (ut)
                model[ui] = (model[ui] == 3) ? 3 : model[ui] + 1;
            else
                model[ui] = (model[ui] == 0) ? 0 : model[ui] - 1;
            if (GSHARE)
                ghr = (ghr * 2 + int'(ut)) % N;
        end
        if (lv) begin
            e.idx   = (ei >= 0) ? ei : idx;
            e.taken = (et >= 0) ? et : int'(model[idx] >= 2);
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset(input int mid_init);
        int n;
        @(posedge clk);
        #2;
        reset       = 1'b1;
        lookupValid = 1'b0;
        updateValid = 1'b0;
        sbq.delete();
        last_t = 0;
        last_i = 0;
        #1;
        chk("reset_ready", int'(ready), 0);
        chk("reset_predValid", int'(predValid), 0);
        chk("reset_predTaken", int'(predTaken), 0);
        chk("reset_predIndex", int'(predIndex), 0);
        for (int i = 0; i < N; i++) model[i] = 2;
        ghr = 0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        // Traffic during INIT must be ignored entirely.
        lookupValid = 1'b1;
        lookupPC    = 32'h0000_0104;
        updateValid = 1'b1;
        updateIndex = 6'd3;
        updateTaken = 1'b0;
        if (mid_init > 0) begin
            repeat (mid_init) @(posedge clk);
            #1;
            chk("ready_mid_init", int'(ready), 0);
            #1;
            reset = 1'b1;
            #1;
            chk("mid_init_reset_ready", int'(ready), 0);
            chk("mid_init_reset_predValid", int'(predValid), 0);
            @(posedge clk);
            #2;
            reset = 1'b0;
        end
        n = 0;
        while (!ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        lookupValid = 1'b0;
        updateValid = 1'b0;
        chk("init_cycles", n, N);
    endtask

    initial begin
        for (int i = 0; i < N; i++) model[i] = 2;
        #12;
        do_reset(0);

        step(1'b1, 32'h100, 1'b0, 0, 1'b0, dx(1), dx(0));

        repeat (3) step(1'b0, 32'h0, 1'b1, 5, 1'b0);
        step(1'b1, 32'h14, 1'b0, 0, 1'b0, dx(0), dx(5));
        step(1'b0, 32'h0, 1'b1, 5, 1'b1);
        step(1'b1, 32'h14, 1'b0, 0, 1'b0, dx(0), dx(5));
        step(1'b0, 32'h0, 1'b1, 5, 1'b1);
        step(1'b1, 32'h14, 1'b0, 0, 1'b0, dx(1), dx(5));

        repeat (4) step(1'b0, 32'h0, 1'b1, 9, 1'b1);
        step(1'b0, 32'h0, 1'b1, 9, 1'b0);
        step(1'b1, 32'h24, 1'b0, 0, 1'b0, dx(1), dx(9));
        step(1'b0, 32'h0, 1'b1, 9, 1'b0);
        step(1'b1, 32'h24, 1'b0, 0, 1'b0, dx(0), dx(9));

        step(1'b1, 32'h28, 1'b1, 10, 1'b0, dx(0), dx(10));
        step(1'b1, 32'h2C, 1'b1, 12, 1'b0, dx(1), dx(11));

        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                     | 32'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15),
                 1'($urandom_range(0, 1)));
        end
        idle(2);
        chk("queue_drained_run", sbq.size(), 0);

        step(1'b1, 32'h40, 1'b0, 0, 1'b0);
        do_reset(0);
        step(1'b1, 32'h100, 1'b0, 0, 1'b0, dx(1), dx(0));

        do_reset(30);
        step(1'b1, 32'h14, 1'b0, 0, 1'b0, dx(1), dx(5));
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 63),
                 1'($urandom_range(0, 1)));
        end
        idle(2);

`ifdef BHT_GSHARE_EN
        do_reset(0);
        step(1'b0, 32'h0, 1'b1, 20, 1'b1);
        step(1'b0, 32'h0, 1'b1, 21, 1'b1);
        step(1'b0, 32'h0, 1'b1, 22, 1'b0);
        step(1'b1, 32'h0, 1'b0, 0, 1'b0, 1, 6);
        idle(2);
`endif

        chk("queue_drained_end", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
